// File: rtl/svi_array_capture_if.sv
// Single-bit lane interface: a latch-based producer elsewhere drives y,
// and the capture block reads it through the P2 modport.
interface I;
  logic y;

  modport P2 (input y);
endinterface

// File: rtl/svi_array_capture.sv
// Consumer of an array of I.P2 lanes: synchronises each lane into i_clk,
// accumulates per-lane changes and hands out snapshots over valid/ready.
module svi_array_capture #(
  parameter int SIZE  = 8,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_srst,
  I.P2                     p2 [SIZE-1:0],
  input  logic             i_en,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [SIZE-1:0]  o_data,
  output logic [SIZE-1:0]  o_chg,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_ovf
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SIZE-1:0]  lane_y;
  logic [SIZE-1:0]  s1_q, s2_q, s3_q;
  logic [SIZE-1:0]  nc;
  logic [SIZE-1:0]  pend_d, pend_q;
  logic [SIZE-1:0]  data_d, data_q;
  logic [SIZE-1:0]  chg_d, chg_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             valid_d, valid_q;
  logic             ovf_d, ovf_q;
  logic             load_req;
  logic             load;
  state_e           state_d, state_q;

  for (genvar g = 0; g < SIZE; g++) begin : g_lane
    assign lane_y[g] = p2[g].y;
  end

  // s1 is the only stage that sees the asynchronous lane values.
  always_ff @(posedge i_clk) begin
    if (!i_srst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= lane_y;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign nc       = s2_q ^ s3_q;
  assign load_req = i_en && ((pend_q | nc) != '0);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    data_d  = data_q;
    chg_d   = chg_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    load    = 1'b0;

    if (i_en) begin
      pend_d = pend_q | nc;
    end

    unique case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (load_req) begin
          load = 1'b1;
        end
      end
      ST_HOLD: begin
        valid_d = 1'b1;
        if (i_ready) begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (load_req) begin
            load = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // A load absorbs this cycle's changes, so they can never count as lost.
    if (load) begin
      data_d  = s2_q;
      chg_d   = pend_q | nc;
      pend_d  = '0;
      valid_d = 1'b1;
      state_d = ST_HOLD;
    end

    if (i_en && ((nc & pend_q) != '0) && !load) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_srst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      chg_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      chg_q   <= chg_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_chg   = chg_q;
  assign o_cnt   = cnt_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_svi_array_capture.sv
// Directed bench for svi_array_capture: a default instance plus a CNT_W=2
// instance share all stimulus so counter saturation is visible quickly.
module tb_svi_array_capture;

  logic       clk = 1'b0;
  logic       srst_n;
  logic       en;
  logic       ready;
  logic [7:0] lane_y;

  logic       valid8, ovf8, valid2, ovf2;
  logic [7:0] data8, chg8, data2, chg2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  I if8 [7:0] ();
  I if2 [7:0] ();

  for (genvar g = 0; g < 8; g++) begin : g_drv
    assign if8[g].y = lane_y[g];
    assign if2[g].y = lane_y[g];
  end

  svi_array_capture #(.SIZE(8), .CNT_W(8)) dut8 (
    .i_clk(clk), .i_srst(srst_n), .p2(if8), .i_en(en), .o_valid(valid8),
    .i_ready(ready), .o_data(data8), .o_chg(chg8), .o_cnt(cnt8), .o_ovf(ovf8)
  );

  svi_array_capture #(.SIZE(8), .CNT_W(2)) dut2 (
    .i_clk(clk), .i_srst(srst_n), .p2(if2), .i_en(en), .o_valid(valid2),
    .i_ready(ready), .o_data(data2), .o_chg(chg2), .o_cnt(cnt2), .o_ovf(ovf2)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Clears every lane and holds reset long enough to flush the sync stages.
  task automatic do_reset();
    srst_n = 1'b0;
    lane_y = 8'h00;
    step(3);
    srst_n = 1'b1;
  endtask

  task automatic test_reset();
    srst_n = 1'b0;
    en     = 1'b1;
    ready  = 1'b0;
    lane_y = 8'h00;
    for (int c = 0; c < 10; c++) begin
      step(1);
      checks++;
      if (valid8 !== 1'b0 || cnt8 !== 8'd0 || ovf8 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_hold cyc%0d: valid=%b cnt=%0d ovf=%b, want 0 0 0", c, valid8, cnt8, ovf8);
      end
    end
    srst_n = 1'b1;
    step(4);
    checks++;
    if (valid8 !== 1'b0 || data8 !== 8'h00 || chg8 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_release: valid=%b data=%h chg=%h, want 0 00 00", valid8, data8, chg8);
    end
  endtask

  task automatic test_single_change();
    do_reset();
    en     = 1'b1;
    ready  = 1'b1;
    lane_y = 8'h08;
    step(2);
    checks++;
    if (valid8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_early: valid=%b, want 0", valid8);
    end
    step(1);
    checks++;
    if (valid8 !== 1'b1 || data8 !== 8'h08 || chg8 !== 8'h08 || cnt8 !== 8'd0) begin
      errors++;
      $display("[TB] FAIL single_load: valid=%b data=%h chg=%h cnt=%0d, want 1 08 08 0", valid8, data8, chg8, cnt8);
    end
    step(1);
    checks++;
    if (valid8 !== 1'b0 || cnt8 !== 8'd1) begin
      errors++;
      $display("[TB] FAIL single_done: valid=%b cnt=%0d, want 0 1", valid8, cnt8);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    en     = 1'b1;
    ready  = 1'b0;
    lane_y = 8'h01;
    step(2);
    lane_y = 8'h21;
    step(1);
    checks++;
    if (valid8 !== 1'b1 || chg8 !== 8'h01 || data8 !== 8'h01) begin
      errors++;
      $display("[TB] FAIL b2b_first: valid=%b data=%h chg=%h, want 1 01 01", valid8, data8, chg8);
    end
    step(2);
    checks++;
    if (valid8 !== 1'b1 || chg8 !== 8'h01 || data8 !== 8'h01) begin
      errors++;
      $display("[TB] FAIL b2b_stable: valid=%b data=%h chg=%h, want 1 01 01", valid8, data8, chg8);
    end
    ready = 1'b1;
    step(1);
    checks++;
    if (valid8 !== 1'b1 || chg8 !== 8'h20 || data8 !== 8'h21 || cnt8 !== 8'd1) begin
      errors++;
      $display("[TB] FAIL b2b_reload: valid=%b data=%h chg=%h cnt=%0d, want 1 21 20 1", valid8, data8, chg8, cnt8);
    end
    step(1);
    checks++;
    if (valid8 !== 1'b0 || cnt8 !== 8'd2) begin
      errors++;
      $display("[TB] FAIL b2b_drain: valid=%b cnt=%0d, want 0 2", valid8, cnt8);
    end
    ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    en     = 1'b1;
    ready  = 1'b0;
    lane_y = 8'h01;
    step(3);
    lane_y = 8'h05;
    step(5);
    lane_y = 8'h01;
    step(2);
    checks++;
    if (ovf8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_early: ovf=%b, want 0", ovf8);
    end
    step(1);
    checks++;
    if (ovf8 !== 1'b1 || valid8 !== 1'b1 || chg8 !== 8'h01) begin
      errors++;
      $display("[TB] FAIL ovf_set: ovf=%b valid=%b chg=%h, want 1 1 01", ovf8, valid8, chg8);
    end
    ready = 1'b1;
    step(1);
    checks++;
    if (valid8 !== 1'b1 || chg8 !== 8'h04 || data8 !== 8'h01) begin
      errors++;
      $display("[TB] FAIL ovf_reload: valid=%b data=%h chg=%h, want 1 01 04", valid8, data8, chg8);
    end
    step(4);
    checks++;
    if (ovf8 !== 1'b1 || valid8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_sticky: ovf=%b valid=%b, want 1 0", ovf8, valid8);
    end
    srst_n = 1'b0;
    step(1);
    checks++;
    if (ovf8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_reset: ovf=%b, want 0", ovf8);
    end
    srst_n = 1'b1;
    ready  = 1'b0;
  endtask

  task automatic test_enable();
    do_reset();
    en     = 1'b0;
    ready  = 1'b1;
    lane_y = 8'h42;
    for (int c = 0; c < 6; c++) begin
      step(1);
      checks++;
      if (valid8 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL en_off cyc%0d: valid=%b, want 0", c, valid8);
      end
    end
    en = 1'b1;
    step(4);
    checks++;
    if (valid8 !== 1'b0 || data8 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL en_reenable: valid=%b data=%h, want 0 00", valid8, data8);
    end
    lane_y = 8'h40;
    step(3);
    checks++;
    if (valid8 !== 1'b1 || data8 !== 8'h40 || chg8 !== 8'h02) begin
      errors++;
      $display("[TB] FAIL en_next_change: valid=%b data=%h chg=%h, want 1 40 02", valid8, data8, chg8);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    en    = 1'b1;
    ready = 1'b1;
    for (int h = 1; h <= 5; h++) begin
      lane_y = lane_y ^ 8'h01;
      step(4);
      checks++;
      if (valid8 !== 1'b0 || cnt8 !== 8'(h) || cnt2 !== 2'((h > 3) ? 3 : h)) begin
        errors++;
        $display("[TB] FAIL sat_hs%0d: valid=%b cnt8=%0d cnt2=%0d, want 0 %0d %0d",
                 h, valid8, cnt8, cnt2, h, (h > 3) ? 3 : h);
      end
    end
    ready  = 1'b0;
    lane_y = lane_y ^ 8'h01;
    step(3);
    checks++;
    if (valid2 !== 1'b1 || cnt2 !== 2'd3) begin
      errors++;
      $display("[TB] FAIL sat_hold: valid2=%b cnt2=%0d, want 1 3", valid2, cnt2);
    end
    srst_n = 1'b0;
    step(1);
    checks++;
    if (valid2 !== 1'b0 || cnt2 !== 2'd0 || ovf2 !== 1'b0 || valid8 !== 1'b0 || cnt8 !== 8'd0) begin
      errors++;
      $display("[TB] FAIL sat_reset: valid2=%b cnt2=%0d ovf2=%b valid8=%b cnt8=%0d, want 0 0 0 0 0",
               valid2, cnt2, ovf2, valid8, cnt8);
    end
    srst_n = 1'b1;
  endtask

  task automatic test_post_reset();
    srst_n = 1'b0;
    en     = 1'b1;
    ready  = 1'b0;
    lane_y = 8'h10;
    step(3);
    srst_n = 1'b1;
    step(2);
    checks++;
    if (valid8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_early: valid=%b, want 0", valid8);
    end
    step(1);
    checks++;
    if (valid8 !== 1'b1 || data8 !== 8'h10 || chg8 !== 8'h10 || data2 !== 8'h10) begin
      errors++;
      $display("[TB] FAIL post_reset_load: valid=%b data=%h chg=%h data2=%h, want 1 10 10 10",
               valid8, data8, chg8, data2);
    end
  endtask

  initial begin
    srst_n = 1'b0;
    en     = 1'b0;
    ready  = 1'b0;
    lane_y = 8'h00;
    test_reset();
    test_single_change();
    test_back_to_back();
    test_overflow();
    test_enable();
    test_saturation();
    test_post_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/svi_array_capture.md
Name: svi_array_capture

Overview:
- Consumer end of the `I` interface array.
- Reads `SIZE` scalar `y` lanes through `I.P2` modport ports, which are driven by latch-based producers in another block.
- Synchronises each lane into `i_clk`, detects per-lane changes and accumulates them.
- Delivers snapshots (lane values plus change mask) over a valid/ready handshake, and keeps a transfer counter and a lost-event flag.

Parameters:
- SIZE, 8, number of `I` interface instances (lanes) in the `p2` array.
- CNT_W, 8, width of the saturating transfer counter.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_srst  input  1  reset; synchronous, active-low.
- p2  input (`I.P2` interface array)  [SIZE-1:0]  lane `i` value is `p2[i].y`; asynchronous to `i_clk`.
- i_en  input  1  capture enable.
- o_valid  output  1  snapshot available.
- i_ready  input  1  downstream accepts the snapshot.
- o_data  output  SIZE  synchronised lane values at load time.
- o_chg  output  SIZE  lanes that changed since the previous load.
- o_cnt  output  CNT_W  completed handshakes, saturating.
- o_ovf  output  1  sticky; a lane changed again before its pending change was delivered.

Behaviour:
- Reset (`i_srst` == 0 at a rising edge):
  - Sync stages `s1`, `s2`, `s3`, the pending mask `pend`, `o_valid`, `o_data`, `o_chg`, `o_cnt` and `o_ovf` all go to 0.
  - State goes to IDLE.
  - Asserting reset mid-transfer drops the held snapshot without a handshake.
- Synchroniser:
  - Per lane, `s1` <= `p2[i].y`, `s2` <= `s1`, `s3` <= `s2`, every cycle regardless of `i_en`.
  - New-change vector is `nc = s2 ^ s3` (combinational).
- Accumulation:
  - When `i_en` == 1, `pend` collects `nc`.
  - When `i_en` == 0, `nc` is discarded and `pend` is held.
  - `o_ovf` sets when `i_en` & (`nc` & `pend` != 0) in a cycle where `pend` is not being cleared.
  - `o_ovf` clears only on reset.
- Latency: an input change stable before edge E0 reaches `s1` at E0 and `s2` at E1, and is loaded with `o_valid` = 1 at E2. It is therefore visible in the cycle after the third edge.
- FSM, IDLE:
  - `o_valid` = 0.
  - If `i_en` & (`pend` | `nc`) != 0: load `o_data` <= `s2`, `o_chg` <= `pend` | `nc`, `pend` <= 0, `o_valid` <= 1, go to HOLD.
- FSM, HOLD:
  - `o_valid` = 1; `o_data` and `o_chg` are stable until the handshake.
  - New changes keep accumulating into `pend`.
  - On `i_ready` = 1, `o_cnt` increments, saturating at 2^CNT_W-1.
    - If `i_en` & (`pend` | `nc`) != 0 at the same edge: reload as in IDLE and stay in HOLD (back-to-back snapshots).
    - Otherwise: `o_valid` <= 0, go to IDLE.
  - `i_en` dropping in HOLD does not cancel the held snapshot.
- Simultaneous events:
  - A change and a load in the same cycle: the change is included in `o_chg`, `pend` becomes 0, and `o_ovf` is not set.
  - A lane toggling twice within the sync window (net `nc` = 0) is not reported; this is accepted.
- Post-reset: a lane held at 1 across reset release produces a 0->1 change 3 edges after release (when `i_en` = 1).
- No combinational path from `i_ready` to `o_valid`; all outputs are registered.

Test Plan:
- Reset with all `y` = 0, `i_en` = 1, hold 10 cycles -> `o_valid` = 0, `o_cnt` = 0, `o_ovf` = 0 throughout.
- Set `p2[3].y` = 1 before edge E0, `i_ready` = 1 -> `o_valid` = 1 after E2, `o_data` = 8'h08, `o_chg` = 8'h08; next edge `o_valid` = 0, `o_cnt` = 1.
- `i_ready` = 0; toggle lane 0 then lane 5 two cycles later -> first snapshot `o_chg` = 8'h01 held stable; raising `i_ready` gives a back-to-back reload with `o_chg` = 8'h20, `o_data` = 8'h21, `o_valid` stays 1.
- `i_ready` = 0 while lane 2 goes 0->1, then 1->0 five cycles later, with a snapshot already held -> `o_ovf` = 1 and stays 1 until reset.
- `i_en` = 0 while lanes 1 and 6 change -> no `o_valid`. Re-enable with no further changes -> still no `o_valid`, and `o_data` updates only on the next real change.
- Set CNT_W = 2 and complete 5 handshakes -> `o_cnt` = 3. Assert `i_srst` = 0 during HOLD -> next edge `o_valid` = 0, `o_cnt` = 0, `o_ovf` = 0.
